cntr_capture_compare: RTL and testbench

- Capture/compare stage that consumes the N-bit free-running count produced by the team's counter block.
- It timestamps an external asynchronous event: it samples the count on a selected edge of a synchronised input pin.
- It also generates a double-buffered compare match pulse and a PWM output from the same count.
- It sits directly downstream of the counter; the counter's output drives cnt_in unmodified.

---
 rtl/cntr_pkg.sv | 24 ++
 rtl/sync_edge_det.sv | 30 +++
 rtl/cntr_capture_compare.sv | 103 ++++++++++
 tb/tb_cntr_capture_compare.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cntr_pkg.sv
// Shared definitions for the capture/compare stage and its pin-sampling helpers.
// Covers the edge-select encodings and the function that turns rise/fall into a capture strobe.
package cntr_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_sel_e;

    function automatic logic edge_select(input logic rise, input logic fall, input logic [1:0] sel);
        logic hit;
        hit = 1'b0;
        case (sel)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous pin, plus one delay stage for edge detection.
// The rise and fall outputs are single-cycle strobes in the clk domain.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/cntr_capture_compare.sv
// Capture/compare stage: timestamps edges on cap_pin with the upstream count and produces
// a double-buffered compare match pulse, a PWM output and a period-start pulse.
module cntr_capture_compare
    import cntr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] cnt_in,
    input  logic         cap_pin,
    input  logic [1:0]   cap_edge_sel,
    input  logic         cap_rd,
    input  logic         cmp_wr,
    input  logic [N-1:0] cmp_wdata,
    output logic [N-1:0] cap_val,
    output logic         cap_valid,
    output logic         cap_ovr,
    output logic         cmp_match,
    output logic         pwm_out,
    output logic         period_start
);

    logic         w_rise;
    logic         w_fall;
    logic         w_edge_hit;
    logic         w_ps;
    logic [N-1:0] w_cmp_active_next;

    logic [N-1:0] r_cap_val;
    logic         r_cap_valid;
    logic         r_cap_ovr;
    logic         r_cmp_match;
    logic         r_pwm;
    logic         r_period_start;
    logic [N-1:0] r_cmp_shadow;
    logic [N-1:0] r_cmp_active;
    logic [N-1:0] r_cnt_prev;

    sync_edge_det u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (cap_pin),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_edge_hit = edge_select(w_rise, w_fall, cap_edge_sel);

    // A period starts on any arrival at zero, so an upstream counter reset also restarts the period.
    assign w_ps = (cnt_in == '0) && (r_cnt_prev != '0);

    // The shadow value before any same-cycle write is what goes live at a period start.
    assign w_cmp_active_next = w_ps ? r_cmp_shadow : r_cmp_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_prev     <= '1;
            r_period_start <= 1'b0;
            r_cmp_shadow   <= '0;
            r_cmp_active   <= '0;
            r_cmp_match    <= 1'b0;
            r_pwm          <= 1'b0;
        end else begin
            r_cnt_prev     <= cnt_in;
            r_period_start <= w_ps;
            r_cmp_active   <= w_cmp_active_next;
            if (cmp_wr) begin
                r_cmp_shadow <= cmp_wdata;
            end
            r_cmp_match    <= (cnt_in == w_cmp_active_next);
            r_pwm          <= (cnt_in < w_cmp_active_next);
        end
    end

    // A capture coinciding with a read wins; the read still consumed the old value, so no overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_val   <= '0;
            r_cap_valid <= 1'b0;
            r_cap_ovr   <= 1'b0;
        end else if (w_edge_hit) begin
            r_cap_val   <= cnt_in;
            r_cap_valid <= 1'b1;
            if (cap_rd) begin
                r_cap_ovr <= 1'b0;
            end else if (r_cap_valid) begin
                r_cap_ovr <= 1'b1;
            end
        end else if (cap_rd) begin
            r_cap_valid <= 1'b0;
            r_cap_ovr   <= 1'b0;
        end
    end

    assign cap_val      = r_cap_val;
    assign cap_valid    = r_cap_valid;
    assign cap_ovr      = r_cap_ovr;
    assign cmp_match    = r_cmp_match;
    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_cntr_capture_compare.sv
// Self-checking bench for cntr_capture_compare: directed table, directed capture/compare
// sequences, asynchronous reset, and randomized traffic against a behavioural model.
module tb_cntr_capture_compare;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] cnt_in;
    logic         cap_pin;
    logic [1:0]   cap_edge_sel;
    logic         cap_rd;
    logic         cmp_wr;
    logic [N-1:0] cmp_wdata;
    logic [N-1:0] cap_val;
    logic         cap_valid;
    logic         cap_ovr;
    logic         cmp_match;
    logic         pwm_out;
    logic         period_start;

    int n_tests;
    int n_fail;

    cntr_capture_compare #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .cnt_in       (cnt_in),
        .cap_pin      (cap_pin),
        .cap_edge_sel (cap_edge_sel),
        .cap_rd       (cap_rd),
        .cmp_wr       (cmp_wr),
        .cmp_wdata    (cmp_wdata),
        .cap_val      (cap_val),
        .cap_valid    (cap_valid),
        .cap_ovr      (cap_ovr),
        .cmp_match    (cmp_match),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: pin history as a queue of per-edge samples (index 0 = newest).
    logic         pin_hist[$];
    logic [N-1:0] m_cap_val;
    logic         m_valid, m_ovr, m_match, m_pwm, m_ps;
    logic [N-1:0] m_shadow, m_active;
    int           m_prev;

    task automatic m_reset();
        pin_hist = {1'b0, 1'b0, 1'b0};
        m_cap_val = '0; m_valid = 1'b0; m_ovr = 1'b0;
        m_match = 1'b0; m_pwm = 1'b0; m_ps = 1'b0;
        m_shadow = '0; m_active = '0;
        m_prev = -1;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic m_edge();
        logic seen_now, seen_before, hit, start;
        int cnt, cmp_val;
        seen_now    = pin_hist[1];
        seen_before = pin_hist[2];
        case (cap_edge_sel)
            2'b00:   hit = seen_now && !seen_before;
            2'b01:   hit = !seen_now && seen_before;
            2'b10:   hit = seen_now != seen_before;
            default: hit = 1'b0;
        endcase
        cnt   = int'(cnt_in);
        start = (cnt == 0) && (m_prev != 0);
        if (start) m_active = m_shadow;
        cmp_val = int'(m_active);
        if (hit) begin
            m_ovr     = cap_rd ? 1'b0 : (m_valid ? 1'b1 : m_ovr);
            m_cap_val = cnt_in;
            m_valid   = 1'b1;
        end else if (cap_rd) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        if (cmp_wr) m_shadow = cmp_wdata;
        m_match = (cnt == cmp_val);
        m_pwm   = (cnt < cmp_val);
        m_ps    = start;
        m_prev  = cnt;
        pin_hist.push_front(cap_pin);
        void'(pin_hist.pop_back());
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        logic [N+4:0] act, exp;
        act = {cap_val, cap_valid, cap_ovr, cmp_match, pwm_out, period_start};
        exp = {m_cap_val, m_valid, m_ovr, m_match, m_pwm, m_ps};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: {val,vld,ovr,match,pwm,ps} got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // One clock cycle: model sees the current inputs, DUT samples them, outputs checked after the edge.
    task automatic cycle(input string nm);
        m_edge();
        @(posedge clk);
        #1;
        chk_model(nm);
    endtask

    task automatic drive_idle();
        cap_pin = 1'b0; cap_edge_sel = 2'b00; cap_rd = 1'b0;
        cmp_wr = 1'b0; cmp_wdata = '0;
    endtask

    typedef struct {
        logic [N-1:0] cnt;
        logic         wr;
        logic [N-1:0] wdata;
        logic         e_match;
        logic         e_pwm;
        logic         e_ps;
    } vec_t;

    vec_t tbl[18];

    initial begin
        n_tests = 0;
        n_fail  = 0;

        tbl[0]  = '{8'd0,   1'b1, 8'd3,   1'b1, 1'b0, 1'b1};
        tbl[1]  = '{8'd1,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'd2,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'd0,   1'b0, 8'd0,   1'b0, 1'b1, 1'b1};
        tbl[4]  = '{8'd1,   1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        tbl[5]  = '{8'd2,   1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        tbl[6]  = '{8'd3,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0};
        tbl[7]  = '{8'd3,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0};
        tbl[8]  = '{8'd3,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0};
        tbl[9]  = '{8'd4,   1'b1, 8'hFF,  1'b0, 1'b0, 1'b0};
        tbl[10] = '{8'd0,   1'b0, 8'd0,   1'b0, 1'b1, 1'b1};
        tbl[11] = '{8'hFE,  1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        tbl[12] = '{8'hFF,  1'b0, 8'd0,   1'b1, 1'b0, 1'b0};
        tbl[13] = '{8'd0,   1'b1, 8'd5,   1'b0, 1'b1, 1'b1};
        tbl[14] = '{8'd0,   1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        tbl[15] = '{8'd7,   1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        tbl[16] = '{8'd0,   1'b0, 8'd0,   1'b0, 1'b1, 1'b1};
        tbl[17] = '{8'd5,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        cnt_in = '0;
        drive_idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cap_val", 32'(cap_val), 32'd0);
        chk("rst_flags", {27'd0, cap_valid, cap_ovr, cmp_match, pwm_out, period_start}, 32'd0);
        reset = 1'b0;

        // Compare/PWM path table, starting from reset state.
        for (int i = 0; i < 18; i++) begin
            cnt_in    = tbl[i].cnt;
            cmp_wr    = tbl[i].wr;
            cmp_wdata = tbl[i].wdata;
            cycle($sformatf("tbl%0d_model", i));
            chk($sformatf("tbl%0d_cmp", i), {29'd0, cmp_match, pwm_out, period_start},
                {29'd0, tbl[i].e_match, tbl[i].e_pwm, tbl[i].e_ps});
        end
        drive_idle();

        // Fresh reset, then capture sequences on a free-running count.
        #2 reset = 1'b1;
        #1 m_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 86; k++) begin
            cnt_in  = N'(k);
            cap_pin = (k >= 10 && k < 20) || (k >= 30 && k < 45) || (k >= 50 && k < 55) ||
                      (k >= 60 && k < 66) || (k >= 72 && k < 76);
            cap_edge_sel = (k < 52) ? 2'b00 : (k < 65) ? 2'b10 : (k < 70) ? 2'b11 : 2'b01;
            cap_rd = (k == 40) || (k == 62);
            cycle($sformatf("cap_k%0d", k));
            case (k)
                11: chk("cap_latency_not_yet", 32'(cap_valid), 32'd0);
                12: chk("cap_first", {cap_val, cap_valid, cap_ovr}, {8'd12, 1'b1, 1'b0});
                22: chk("cap_fall_ignored_rise_mode", 32'(cap_val), 32'd12);
                32: chk("cap_overrun", {cap_val, cap_valid, cap_ovr}, {8'd32, 1'b1, 1'b1});
                40: chk("cap_read_clears", {cap_valid, cap_ovr}, 2'b00);
                52: chk("cap_after_read", {cap_val, cap_valid, cap_ovr}, {8'd52, 1'b1, 1'b0});
                57: chk("cap_both_fall_ovr", {cap_val, cap_valid, cap_ovr}, {8'd57, 1'b1, 1'b1});
                62: chk("cap_rd_same_cycle", {cap_val, cap_valid, cap_ovr}, {8'd62, 1'b1, 1'b0});
                74: chk("cap_off_and_rise_in_fall_mode", 32'(cap_val), 32'd62);
                78: chk("cap_fall_mode", {cap_val, cap_valid, cap_ovr}, {8'd78, 1'b1, 1'b1});
                default: ;
            endcase
        end
        cap_rd = 1'b0;
        cap_pin = 1'b0;

        // Double-buffered compare across three wraps.
        for (int k = 86; k < 1024; k++) begin
            cnt_in    = N'(k);
            cmp_wr    = (k == 100) || (k == 512);
            cmp_wdata = (k == 100) ? 8'd64 : 8'd200;
            cycle("cmp_seq");
            case (k)
                200:      chk("cmp_pwm_before_wrap", 32'(pwm_out), 32'd0);
                256:      chk("cmp_wrap_load", {period_start, pwm_out, cmp_match}, 3'b110);
                256 + 63: chk("cmp_pwm_63", {pwm_out, cmp_match}, 2'b10);
                256 + 64: chk("cmp_match_64", {pwm_out, cmp_match}, 2'b01);
                256 + 65: chk("cmp_after_64", {pwm_out, cmp_match}, 2'b00);
                512:      chk("cmp_wr_at_wrap_ps", 32'(period_start), 32'd1);
                512 + 64: chk("cmp_old_shadow_active", {pwm_out, cmp_match}, 2'b01);
                512 + 100: chk("cmp_pwm_100", 32'(pwm_out), 32'd0);
                768 + 199: chk("cmp_pwm_199", {pwm_out, cmp_match}, 2'b10);
                768 + 200: chk("cmp_match_200", {pwm_out, cmp_match}, 2'b01);
                default: ;
            endcase
        end
        cmp_wr = 1'b0;

        // Asynchronous reset between edges, mid-period, with a capture pending in the synchroniser.
        cnt_in = 8'd10;
        cap_edge_sel = 2'b00;
        cap_pin = 1'b1;
        cycle("pre_reset");
        #2 reset = 1'b1;
        #1;
        chk("async_rst_outputs", {cap_val, cap_valid, cap_ovr, cmp_match, pwm_out, period_start}, '0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        cnt_in = 8'd0;
        cycle("post_rst_first_zero");
        chk("post_rst_ps", {period_start, pwm_out, cmp_match}, 3'b101);
        cnt_in = 8'd1;
        cycle("post_rst_one");
        chk("post_rst_pwm", {pwm_out, cap_valid}, 2'b00);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(99))
                0, 1, 2:          cnt_in = '0;
                3, 4:             cnt_in = N'($urandom);
                5, 6, 7, 8, 9:    cnt_in = cnt_in;
                default:          cnt_in = cnt_in + 1'b1;
            endcase
            if ($urandom_range(5) == 0) cap_pin = ~cap_pin;
            if ($urandom_range(49) == 0) cap_edge_sel = 2'($urandom);
            cap_rd    = ($urandom_range(7) == 0);
            cmp_wr    = ($urandom_range(15) == 0);
            cmp_wdata = N'($urandom);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
